// File: rtl/uart_sched_pkg.sv
// ============================================================================
// Module   : uart_sched_pkg
// Brief    : Shared state encoding and constants for the UART TX scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_TAG     = 3'd1;
    localparam state_t ST_SEND    = 3'd2;
    localparam state_t ST_WAIT_HI = 3'd3;
    localparam state_t ST_WAIT_LO = 3'd4;

    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    localparam int ERR_STALL = 0;
    localparam int ERR_BUSY  = 1;

endpackage

`default_nettype wire

// File: rtl/round_robin_arbiter.sv
// ============================================================================
// Module   : round_robin_arbiter
// Brief    : Stateless round-robin pick of a one-hot winner above a pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_robin_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_in,
    input  logic [PW-1:0] ptr_in,
    output logic [N-1:0]  grant_out,
    output logic [PW-1:0] idx_out,
    output logic          any_out
);

    // Walk from farthest to nearest candidate so the one closest above ptr wins.
    always_comb begin
        grant_out = '0;
        idx_out   = '0;
        any_out   = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req_in[(int'(ptr_in) + k) % N]) begin
                grant_out                              = '0;
                grant_out[(int'(ptr_in) + k) % N]      = 1'b1;
                idx_out                                = PW'((int'(ptr_in) + k) % N);
                any_out                                = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin, packet-locked sharing of one UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TAG_EN        = 0,
    parameter int STALL_TIMEOUT = 1024,
    parameter int BUSY_TIMEOUT  = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    input  logic [NUM_REQ*8-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]     req_last_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    output logic [7:0]             tx_data_out,
    output logic                   tx_trigger_out,
    input  logic                   tx_busy_in,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic                   active_out,
    output logic [1:0]             err_out
);

    localparam int PW   = $clog2(NUM_REQ);
    localparam int CMAX = (STALL_TIMEOUT > BUSY_TIMEOUT) ? STALL_TIMEOUT : BUSY_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    state_t               state_q,  state_d;
    logic [NUM_REQ-1:0]   grant_q,  grant_d;
    logic [PW-1:0]        gid_q,    gid_d;
    logic [PW-1:0]        ptr_q,    ptr_d;
    logic                 active_q, active_d;
    logic [7:0]           data_q,   data_d;
    logic                 trig_q,   trig_d;
    logic                 last_q,   last_d;
    logic                 tag_q,    tag_d;
    logic [1:0]           err_q,    err_d;
    logic [CW-1:0]        cnt_q,    cnt_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;
    logic [7:0]           req_byte;

    round_robin_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req_in    (req_valid_in),
        .ptr_in    (ptr_q),
        .grant_out (arb_grant),
        .idx_out   (arb_idx),
        .any_out   (arb_any)
    );

    assign req_byte = req_data_in[int'(gid_q)*8 +: 8];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        active_d = active_q;
        data_d   = data_q;
        trig_d   = 1'b0;
        last_d   = last_q;
        tag_d    = tag_q;
        err_d    = err_q;
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (arb_any && !tx_busy_in) begin
                    grant_d  = arb_grant;
                    gid_d    = arb_idx;
                    active_d = 1'b1;
                    state_d  = (TAG_EN != 0) ? ST_TAG : ST_SEND;
                end
            end
            ST_TAG: begin
                data_d  = {TAG_NIBBLE, 4'(gid_q)};
                trig_d  = 1'b1;
                tag_d   = 1'b1;
                state_d = ST_WAIT_HI;
            end
            ST_SEND: begin
                if (req_valid_in[gid_q]) begin
                    data_d  = req_byte;
                    trig_d  = 1'b1;
                    last_d  = req_last_in[gid_q];
                    state_d = ST_WAIT_HI;
                end else if (cnt_q >= CW'(STALL_TIMEOUT - 1)) begin
                    err_d[ERR_STALL] = 1'b1;
                    grant_d  = '0;
                    active_d = 1'b0;
                    ptr_d    = gid_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy_in) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q >= CW'(BUSY_TIMEOUT - 1)) begin
                    err_d[ERR_BUSY] = 1'b1;
                    grant_d  = '0;
                    active_d = 1'b0;
                    tag_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy_in) begin
                    if (tag_q) begin
                        tag_d   = 1'b0;
                        state_d = ST_SEND;
                    end else if (last_q) begin
                        grant_d  = '0;
                        active_d = 1'b0;
                        ptr_d    = gid_q;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stall and busy timing both restart whenever the FSM moves.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gid_q    <= '0;
            ptr_q    <= PW'(NUM_REQ - 1);
            active_q <= 1'b0;
            data_q   <= 8'h00;
            trig_q   <= 1'b0;
            last_q   <= 1'b0;
            tag_q    <= 1'b0;
            err_q    <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            ptr_q    <= ptr_d;
            active_q <= active_d;
            data_q   <= data_d;
            trig_q   <= trig_d;
            last_q   <= last_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready_out  = (state_q == ST_SEND) ? grant_q : '0;
    assign tx_data_out    = data_q;
    assign tx_trigger_out = trig_q;
    assign grant_out      = grant_q;
    assign active_out     = active_q;
    assign err_out        = err_q;

    // A requester must hold its byte steady while it waits for ready.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_proto_chk
            a_data_hold: assert property (@(posedge clk_in) disable iff (!rst_n_in)
                (req_valid_in[i] && !req_ready_out[i]) |=>
                (!req_valid_in[i] || $stable(req_data_in[i*8 +: 8])));
        end
    endgenerate

endmodule

`default_nettype wire
